// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   ID-stage register hazard tracker. Every in-flight register write is held
//   as an entry {pend, age, lat}: age counts cycles since issue, lat is the
//   number of cycles until the result can be forwarded. A read of a pending
//   register either forwards from tap 'age' (result ready) or raises a stall.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   issue_valid           ID holds an instruction trying to issue
//   rd_en1/2, rd_addr1/2  operand register reads
//   wr_en, wr_addr        destination write of the issuing instruction
//   wr_lat                result latency (0 -> 1, clamped to FWD_DEPTH)
//   flush                 squash the instructions in EX and ID
//   stall                 ID/IF hold request
//   src_sel1/2            0 = register file, k = forwarding tap k
//   stall_cnt             saturating count of stall cycles
module hazard_scoreboard #(
   parameter int REG_NUM   = 32,
   parameter int ADDR_W    = 5,
   parameter int FWD_DEPTH = 3,
   parameter int SEL_W     = 2,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              rd_en1,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic              rd_en2,
   input  logic [ADDR_W-1:0] rd_addr2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [SEL_W-1:0]  wr_lat,
   input  logic              flush,
   output logic              stall,
   output logic [SEL_W-1:0]  src_sel1,
   output logic [SEL_W-1:0]  src_sel2,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [SEL_W-1:0] DEPTH = SEL_W'(FWD_DEPTH);
   localparam logic [SEL_W-1:0] ONE   = SEL_W'(1);

   logic [REG_NUM-1:0]            pend;
   logic [REG_NUM-1:0][SEL_W-1:0] age;
   logic [REG_NUM-1:0][SEL_W-1:0] lat;

   logic             hazard1, hazard2;
   logic             accept;
   logic [SEL_W-1:0] lat_s;

   // Returns {hazard, sel} for one operand from the current (pre-edge) state,
   // so an instruction reading its own destination sees the older producer.
   function automatic logic [SEL_W:0] lookup(input logic en, input logic [ADDR_W-1:0] addr);
      logic [SEL_W:0] res;
      res = '0;
      if (en && addr != '0 && pend[addr]) begin
         if (age[addr] >= lat[addr]) res = {1'b0, age[addr]};
         else                        res = {1'b1, {SEL_W{1'b0}}};
      end
      return res;
   endfunction

   always_comb begin
      {hazard1, src_sel1} = lookup(rd_en1, rd_addr1);
      {hazard2, src_sel2} = lookup(rd_en2, rd_addr2);
      stall  = issue_valid & ~flush & (hazard1 | hazard2);
      accept = issue_valid & ~stall & ~flush;
   end

   always_comb begin
      lat_s = wr_lat;
      if (wr_lat == '0)        lat_s = ONE;
      else if (wr_lat > DEPTH) lat_s = DEPTH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend      <= '0;
         age       <= '0;
         lat       <= '0;
         stall_cnt <= '0;
      end else begin
         // Age every entry. An age-1 entry belongs to the instruction in EX,
         // which a flush squashes; an entry at the last tap has reached the
         // write-through register file and retires.
         for (int r = 1; r < REG_NUM; r++) begin
            if (pend[r]) begin
               if ((flush && age[r] == ONE) || age[r] == DEPTH) begin
                  pend[r] <= 1'b0;
                  age[r]  <= '0;
                  lat[r]  <= '0;
               end else begin
                  age[r] <= age[r] + ONE;
               end
            end
         end
         // The issuing producer is younger than any tracked one, so it wins.
         if (accept && wr_en && wr_addr != '0) begin
            pend[wr_addr] <= 1'b1;
            age[wr_addr]  <= ONE;
            lat[wr_addr]  <= lat_s;
         end
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid, rd_en1, rd_en2, wr_en, flush;
   logic [4:0] rd_addr1, rd_addr2, wr_addr;
   logic [1:0] wr_lat;
   logic       stall;
   logic [1:0] src_sel1, src_sel2;
   logic [31:0] stall_cnt;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid),
      .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_lat(wr_lat), .flush(flush),
      .stall(stall), .src_sel1(src_sel1), .src_sel2(src_sel2), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        stall;
      logic [1:0]  sel1;
      logic [1:0]  sel2;
      logic        chk_sel;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   exp_cnt = 0;

   task automatic push(input string nm, input logic s, input logic [1:0] s1,
                       input logic [1:0] s2);
      exp_t e;
      e.name = nm; e.stall = s; e.sel1 = s1; e.sel2 = s2;
      e.chk_sel = ~s; e.cnt = 32'(exp_cnt);
      exp_q.push_back(e);
      if (s) exp_cnt++;
   endtask

   // One ID cycle: drive just after the rising edge, push the expectation.
   task automatic cyc(input string nm, input logic iv,
                      input logic e1, input logic [4:0] a1,
                      input logic e2, input logic [4:0] a2,
                      input logic we, input logic [4:0] wa, input logic [1:0] wl,
                      input logic fl,
                      input logic xs, input logic [1:0] x1, input logic [1:0] x2);
      @(posedge clk); #1;
      issue_valid = iv; rd_en1 = e1; rd_addr1 = a1; rd_en2 = e2; rd_addr2 = a2;
      wr_en = we; wr_addr = wa; wr_lat = wl; flush = fl;
      push(nm, xs, x1, x2);
   endtask

   // Monitor: samples on the falling edge (and on a reset rise) whenever an
   // expectation is waiting.
   initial begin
      forever begin
         @(negedge clk or posedge rst);
         #1;
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || stall_cnt !== e.cnt ||
                (e.chk_sel && (src_sel1 !== e.sel1 || src_sel2 !== e.sel2))) begin
               failures++;
               $display("FAIL %s: got stall=%0b sel1=%0d sel2=%0d cnt=%0d, want stall=%0b sel1=%0d sel2=%0d cnt=%0d",
                        e.name, stall, src_sel1, src_sel2, stall_cnt,
                        e.stall, e.sel1, e.sel2, e.cnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      issue_valid = 1'b1; rd_en1 = 1'b1; rd_addr1 = 5'd5; rd_en2 = 1'b1; rd_addr2 = 5'd3;
      wr_en = 1'b1; wr_addr = 5'd5; wr_lat = 2'd1; flush = 1'b0;
      #2 push("reset", 1'b0, 2'd0, 2'd0);
      #10 rst = 1'b0;

      // tap walk
      cyc("addi_r5",  1, 0,0, 0,0, 1,5'd5,2'd1, 0, 0,0,0);
      cyc("walk_t1",  1, 1,5'd5, 0,0, 0,0,0, 0, 0,1,0);
      cyc("walk_t2",  1, 1,5'd5, 0,0, 0,0,0, 0, 0,2,0);
      cyc("walk_t3",  1, 1,5'd5, 0,0, 0,0,0, 0, 0,3,0);
      cyc("walk_rf",  1, 1,5'd5, 0,0, 0,0,0, 0, 0,0,0);
      // load-use
      cyc("lw_r3",    1, 0,0, 0,0, 1,5'd3,2'd2, 0, 0,0,0);
      cyc("ld_use_s", 1, 0,0, 1,5'd3, 0,0,0, 0, 1,0,0);
      cyc("ld_use_f", 1, 0,0, 1,5'd3, 0,0,0, 0, 0,0,2);
      // multiplier, dependent on op1 plus an independent op2
      cyc("mul_r7",   1, 0,0, 0,0, 1,5'd7,2'd3, 0, 0,0,0);
      cyc("mul_s1",   1, 1,5'd7, 1,5'd5, 0,0,0, 0, 1,0,0);
      cyc("mul_s2",   1, 1,5'd7, 1,5'd5, 0,0,0, 0, 1,0,0);
      cyc("mul_fwd",  1, 1,5'd7, 1,5'd5, 0,0,0, 0, 0,3,0);
      // register 0 never tracked
      cyc("wr_r0",    1, 0,0, 0,0, 1,5'd0,2'd3, 0, 0,0,0);
      cyc("rd_r0",    1, 1,5'd0, 1,5'd0, 0,0,0, 0, 0,0,0);
      // younger producer overrides
      cyc("lw_r4",    1, 0,0, 0,0, 1,5'd4,2'd2, 0, 0,0,0);
      cyc("addi_r4",  1, 0,0, 0,0, 1,5'd4,2'd1, 0, 0,0,0);
      cyc("override", 1, 1,5'd4, 0,0, 0,0,0, 0, 0,1,0);
      // wr_lat 0 behaves as 1
      cyc("lat0_r8",  1, 0,0, 0,0, 1,5'd8,2'd0, 0, 0,0,0);
      cyc("lat0_rd",  1, 1,5'd8, 0,0, 0,0,0, 0, 0,1,0);
      // idle cycle: pending reads do not stall without issue_valid
      cyc("lw_r10",   1, 0,0, 0,0, 1,5'd10,2'd2, 0, 0,0,0);
      cyc("no_issue", 0, 1,5'd10, 0,0, 0,0,0, 0, 0,0,0);
      // flush
      cyc("lw_r6",    1, 0,0, 0,0, 1,5'd6,2'd2, 0, 0,0,0);
      cyc("flush",    1, 1,5'd6, 0,0, 0,0,0, 1, 0,0,0);
      cyc("post_fl",  1, 1,5'd6, 0,0, 0,0,0, 0, 0,0,0);
      // reset in the middle of a load-use stall
      cyc("lw_r9",    1, 0,0, 0,0, 1,5'd9,2'd2, 0, 0,0,0);
      cyc("pre_rst",  1, 0,0, 1,5'd9, 0,0,0, 0, 1,0,0);
      #6;
      exp_cnt = 0;
      push("async_rst", 1'b0, 2'd0, 2'd0);
      rst = 1'b1;
      #2 rst = 1'b0;
      cyc("post_rst", 1, 0,0, 1,5'd9, 0,0,0, 0, 0,0,0);

      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
         end
         if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard logic; replaces fixed EX/MEM forwarding compare and single-cycle load stall.
- Tracks every in-flight register write with its age and result latency, so any number of forwarding taps and any mix of producer latencies (ALU, load, multiplier) are handled.
- Sits in ID between decode and the operand muxes.
- Outputs per-operand forwarding tap select and a stall request.

Parameters:
- REG_NUM, 32, number of architectural registers (register 0 hard-wired zero, never tracked)
- ADDR_W, 5, register address width
- FWD_DEPTH, 3, number of forwarding taps after ID (tap 1 = EX, 2 = MEM, 3 = WB)
- SEL_W, 2, select width, must be >= clog2(FWD_DEPTH+1)
- CNT_W, 32, stall performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- issue_valid  in  1  ID holds a valid instruction trying to issue
- rd_en1  in  1  operand 1 reads a register
- rd_addr1  in  ADDR_W  operand 1 register
- rd_en2  in  1  operand 2 reads a register
- rd_addr2  in  ADDR_W  operand 2 register
- wr_en  in  1  issuing instruction writes a register
- wr_addr  in  ADDR_W  destination register
- wr_lat  in  SEL_W  cycles after issue until the result is forwardable (ALU=1, load=2, mul=3)
- flush  in  1  branch redirect: squash the instruction in EX and the one in ID
- stall  out  1  ID/IF must hold this cycle
- src_sel1  out  SEL_W  0 = register file, k = forward from tap k
- src_sel2  out  SEL_W  same, for operand 2
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- State per register r (1..REG_NUM-1): pend, age (SEL_W bits), lat (SEL_W bits).
- Reset (async, rst=1): all pend=0, age=0, lat=0, stall_cnt=0. Hence stall=0 and src_sel1/2=0 while in reset and on the first cycle after it.
- Operand lookup (combinational, current state only; operand i uses rd_en_i / rd_addr_i):
  - Not read (rd_en_i=0), addr 0, or pend=0: sel_i=0, no hazard.
  - pend=1 and age >= lat: sel_i=age.
  - pend=1 and age < lat: hazard_i.
- stall = issue_valid & ~flush & (hazard1 | hazard2).
- src_sel outputs are valid whenever stall=0; they are don't-care when stall=1.
- accept = issue_valid & ~stall & ~flush.
- wr_lat sanitising: 0 is treated as 1; values > FWD_DEPTH are clamped to FWD_DEPTH.
- Each rising edge, in this order:
  - Aging: every pend entry increments age. An entry with age==FWD_DEPTH clears pend (value now in the register file; the register file is write-through).
  - Flush: if flush=1, clear every entry with age==1 before aging.
  - Issue: if accept & wr_en & wr_addr!=0, set entry[wr_addr] to pend=1, age=1, lat=sanitised wr_lat. This overrides any older entry for the same register; the younger producer wins.
- Same-instruction read and write of one register (e.g. add r1,r1,r2): the read sees the pre-edge state (old producer). Correct by construction.
- Stall cycles: no accept, but entries keep aging. The stall resolves after exactly lat-age cycles.
- stall_cnt increments each cycle stall=1 and saturates at all-ones.
- Registered state is updated only on clk edges or rst; outputs are combinational from state and inputs (no added latency).

Test Plan (FWD_DEPTH=3):
- Tap walk: cycle 0 issue addi r5 (lat1); cycles 1-4 issue instructions reading r5 as operand 1 -> stall=0 throughout, src_sel1 = 1, 2, 3, 0.
- Load-use: issue lw r3 (lat2); next cycle issue an instruction reading r3 as operand 2 -> stall=1 for 1 cycle, stall_cnt=1; following cycle stall=0, src_sel2=2.
- Multiplier: issue mul r7 (lat3); dependent instruction next cycle -> stall=1 for 2 cycles, then src_sel1=3. Independent reads during that window -> sel=0, but stall still holds ID (in-order).
- Register 0 and override:
  - Write r0 lat3, then read r0 -> stall=0, sel=0.
  - Issue lw r4 (lat2), next cycle addi r4 (lat1), next cycle read r4 -> stall=0, src_sel1=1.
- Flush: issue lw r6; next cycle assert flush while a reader of r6 sits in ID -> stall=0 that cycle; next cycle a reader of r6 gets sel=0.
- Reset mid-stall: during a load-use stall, pulse rst between clock edges -> stall, src_sel1/2 and stall_cnt drop to 0 immediately without waiting for a clock edge.
